alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one external ALU.
// One operation in flight at a time: IDLE grant -> EXEC capture -> RESP handshake.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | operands on the ALU; result and flags captured at the end of the cycle
// RESP  | result presented to the owner until it takes it
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_func,
  input  logic        req0_setflags,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_func,
  input  logic        req1_setflags,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic [3:0]  rsp0_flags,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [3:0]  rsp1_flags,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_func,
  input  logic [31:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,

  output logic [3:0]  flags_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_func;
  logic        r_setflags;
  logic        r_owner;
  logic        r_last_grant;
  logic [31:0] r_result;
  logic [3:0]  r_rflags;
  logic [3:0]  r_flags;

  logic        w_grant_vld;
  logic        w_grant_id;
  logic        w_rsp_take;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    w_rsp_take  = 1'b0;
    case (r_state)
      IDLE: begin
        // Reset gate keeps the ready strobes quiet while rst_n is held low.
        if (rst_n && (req0_valid || req1_valid)) begin
          w_grant_vld = 1'b1;
          if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
          end else begin
            w_grant_id = req1_valid;
          end
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;
        if (w_rsp_take) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_func       <= 2'b00;
      r_setflags   <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_result     <= 32'd0;
      r_rflags     <= 4'd0;
      r_flags      <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_vld) begin
        r_a          <= w_grant_id ? req1_a        : req0_a;
        r_b          <= w_grant_id ? req1_b        : req0_b;
        r_func       <= w_grant_id ? req1_func     : req0_func;
        r_setflags   <= w_grant_id ? req1_setflags : req0_setflags;
        r_owner      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_result <= alu_out;
        r_rflags <= {alu_n, alu_z, alu_c, alu_v};
        if (r_setflags) begin
          r_flags <= {alu_n, alu_z, alu_c, alu_v};
        end
      end
    end
  end

  assign req0_ready = w_grant_vld && !w_grant_id;
  assign req1_ready = w_grant_vld &&  w_grant_id;

  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) &&  r_owner;
  assign rsp0_data  = r_result;
  assign rsp1_data  = r_result;
  assign rsp0_flags = r_rflags;
  assign rsp1_flags = r_rflags;

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_func = r_func;
  assign flags_q  = r_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU and checks directed and random
// transactions against a transaction-level reference.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid, req0_ready, req0_setflags;
  logic [31:0] req0_a, req0_b;
  logic [1:0]  req0_func;
  logic        req1_valid, req1_ready, req1_setflags;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  req1_func;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_func;
  logic        alu_c, alu_z, alu_n, alu_v;
  logic [3:0]  flags_q;

  int checks = 0;
  int errors = 0;
  logic       m_last;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func(req0_func), .req0_setflags(req0_setflags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func(req1_func), .req1_setflags(req1_setflags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
    .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .flags_q(flags_q)
  );

  // Shared ALU: C is carry-out for add and not-borrow for sub.
  logic [32:0] w_t;
  always_comb begin
    w_t     = 33'd0;
    alu_out = 32'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_func)
      2'b00: begin
        w_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = w_t[31:0];
        alu_c = w_t[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      2'b01: begin
        w_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_out = w_t[31:0];
        alu_c = w_t[32];
        alu_v = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      2'b10: alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
    alu_n = alu_out[31];
    alu_z = (alu_out == 32'd0);
  end

  // Reference: {N,Z,C,V,result} from plain integer arithmetic.
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] f);
    longint sa, sb, ua, ub, sr;
    logic [31:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    c = 1'b0;
    v = 1'b0;
    sr = 0;
    case (f)
      2'b00: begin sr = sa + sb; c = (ua + ub) > 64'hFFFF_FFFF; end
      2'b01: begin sr = sa - sb; c = (ua >= ub); end
      default: ;
    endcase
    if (f == 2'b00 || f == 2'b01) begin
      r = sr[31:0];
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else begin
      r = (f == 2'b10) ? (a & b) : (a | b);
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] f, input logic s);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_func = f; req0_setflags = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_func = f; req1_setflags = s;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    m_flags = 4'd0;
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 32'd9, 32'd9, 2'b00, 1'b1);
    set_req(1, 1'b1, 32'd9, 32'd9, 2'b00, 1'b1);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid got %b%b exp 00", rsp0_valid, rsp1_valid); end
    checks++; if (flags_q !== 4'd0) begin errors++;
      $display("FAIL reset_flags_q got %b exp 0000", flags_q); end
    checks++; if ({alu_a, alu_b, alu_func} !== 66'd0) begin errors++;
      $display("FAIL reset_operands got %h %h %b exp 0", alu_a, alu_b, alu_func); end
    checks++; if (rsp0_data !== 32'd0 || rsp1_flags !== 4'd0) begin errors++;
      $display("FAIL reset_result got %h %b exp 0", rsp0_data, rsp1_flags); end
    apply_reset();
  endtask

  task automatic test_single_op();
    @(negedge clk);
    set_req(0, 1'b1, 32'd5, 32'd3, 2'b01, 1'b1);
    rsp0_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL single_grant got %b%b exp 10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++;
      $display("FAIL single_exec got valid %b ready %b exp 0 0", rsp0_valid, req0_ready); end
    @(negedge clk); #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++;
      $display("FAIL single_rsp_valid got %b%b exp 10", rsp0_valid, rsp1_valid); end
    checks++; if (rsp0_data !== 32'd2 || rsp0_flags !== 4'b0010) begin errors++;
      $display("FAIL single_result got %h %b exp 2 0010", rsp0_data, rsp0_flags); end
    checks++; if (flags_q !== 4'b0010) begin errors++;
      $display("FAIL single_flags_q got %b exp 0010", flags_q); end
  endtask

  task automatic test_flags();
    for (int sf = 0; sf < 2; sf++) begin
      @(negedge clk);
      rsp1_ready = 1'b1;
      set_req(1, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00, sf[0]);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++;
        $display("FAIL flags_grant got %b exp 1", req1_ready); end
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h8000_0000 || rsp1_flags !== 4'b1001) begin
        errors++; $display("FAIL flags_rsp got %b %h %b exp 1 80000000 1001",
                            rsp1_valid, rsp1_data, rsp1_flags); end
      checks++; if (flags_q !== (sf == 1 ? 4'b1001 : 4'b0010)) begin errors++;
        $display("FAIL flags_q_sf%0d got %b exp %b", sf, flags_q, (sf == 1 ? 4'b1001 : 4'b0010)); end
    end
  endtask

  task automatic test_logic_zero();
    @(negedge clk);
    rsp0_ready = 1'b1;
    set_req(0, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd0 || rsp0_flags !== 4'b0100) begin
      errors++; $display("FAIL logic_zero got %b %h %b exp 1 0 0100",
                          rsp0_valid, rsp0_data, rsp0_flags); end
    checks++; if (flags_q !== 4'b0100) begin errors++;
      $display("FAIL logic_zero_flags_q got %b exp 0100", flags_q); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(1, 1'b1, 32'd10, 32'd4, 2'b00, 1'b0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rsp1_ready = (i == 5);
      rsp0_ready = 1'b1;
      #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd14 || rsp1_flags !== 4'b0000) begin
        errors++; $display("FAIL bp_hold_%0d got %b %h %b exp 1 0000000e 0000",
                            i, rsp1_valid, rsp1_data, rsp1_flags); end
      checks++; if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin errors++;
        $display("FAIL bp_no_grant_%0d got ready %b rsp0 %b exp 0 0", i, req0_ready, rsp0_valid); end
    end
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin errors++;
      $display("FAIL bp_release got ready %b rsp1 %b exp 1 0", req0_ready, rsp1_valid); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie_alternation();
    logic exp;
    apply_reset();
    set_req(0, 1'b1, 32'd1, 32'd1, 2'b01, 1'b1);
    set_req(1, 1'b1, 32'h8000_0000, 32'd1, 2'b11, 1'b1);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = k[0];
      #1;
      checks++; if (req0_ready !== !exp || req1_ready !== exp) begin errors++;
        $display("FAIL tie_grant_%0d got %b%b exp %b%b", k, req0_ready, req1_ready, !exp, exp); end
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (rsp0_valid !== !exp || rsp1_valid !== exp) begin errors++;
        $display("FAIL tie_rsp_%0d got %b%b exp %b%b", k, rsp0_valid, rsp1_valid, !exp, exp); end
      checks++; if (rsp0_data !== (exp ? 32'h8000_0001 : 32'd0)) begin errors++;
        $display("FAIL tie_data_%0d got %h exp %h", k, rsp0_data, (exp ? 32'h8000_0001 : 32'd0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_exec();
    set_req(0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    set_req(1, 1'b1, 32'd0, 32'd0, 2'b00, 1'b1);
    #1;
    checks++; if (flags_q !== 4'b1000) begin errors++;
      $display("FAIL rexec_pre_flags got %b exp 1000", flags_q); end
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || flags_q !== 4'd0 || rsp1_data !== 32'd0) begin
      errors++; $display("FAIL rexec_reset got %b%b %b %h exp 00 0000 0",
                          rsp0_valid, rsp1_valid, flags_q, rsp1_data); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'd7, 32'd1, 2'b00, 1'b0);
    set_req(1, 1'b1, 32'd7, 32'd1, 2'b00, 1'b0);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
      $display("FAIL rexec_first_tie got %b%b rsp1 %b exp 10 0", req0_ready, req1_ready, rsp1_valid); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_data !== 32'd8 || flags_q !== 4'd0) begin
      errors++; $display("FAIL rexec_after got %b%b %h %b exp 10 8 0000",
                          rsp0_valid, rsp1_valid, rsp0_data, flags_q); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic v0, v1, g, sf;
    logic [1:0] pat;
    logic [35:0] exp;
    logic [31:0] ga;
    int stall;
    apply_reset();
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      pat = 2'($urandom_range(1, 3));
      v0 = pat[0];
      v1 = pat[1];
      set_req(0, v0, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
              2'($urandom), 1'($urandom));
      set_req(1, v1, $urandom, ($urandom_range(0, 3) == 0) ? req1_a : $urandom,
              2'($urandom), 1'($urandom));
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      #1;
      g = (v0 && v1) ? !m_last : v1;
      checks++; if (req0_ready !== !g || req1_ready !== g) begin errors++;
        $display("FAIL rand_grant_%0d got %b%b exp %b%b", t, req0_ready, req1_ready, !g, g); end
      m_last = g;
      ga = g ? req1_a : req0_a;
      exp = g ? ref_op(req1_a, req1_b, req1_func) : ref_op(req0_a, req0_b, req0_func);
      sf = g ? req1_setflags : req0_setflags;
      @(negedge clk);
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_a = $urandom;
      req1_a = $urandom;
      rsp0_ready = 1'($urandom);
      rsp1_ready = 1'($urandom);
      #1;
      checks++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000 || alu_a !== ga) begin
        errors++; $display("FAIL rand_exec_%0d got %b%b%b%b alu_a %h exp 0000 %h",
                            t, req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_a, ga); end
      if (sf) m_flags = exp[35:32];
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        rsp0_ready = g ? 1'($urandom) : (s == stall);
        rsp1_ready = g ? (s == stall) : 1'($urandom);
        #1;
        checks++; if (rsp0_valid !== !g || rsp1_valid !== g || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++; $display("FAIL rand_rsp_%0d_%0d got %b%b ready %b%b exp %b%b 00",
                              t, s, rsp0_valid, rsp1_valid, req0_ready, req1_ready, !g, g); end
        checks++; if (rsp0_data !== exp[31:0] || rsp1_flags !== exp[35:32] || flags_q !== m_flags) begin
          errors++; $display("FAIL rand_data_%0d_%0d got %h %b %b exp %h %b %b", t, s,
                              rsp0_data, rsp1_flags, flags_q, exp[31:0], exp[35:32], m_flags); end
      end
    end
  endtask

  initial begin
    m_last = 1'b1;
    m_flags = 4'd0;
    test_reset();
    test_single_op();
    test_flags();
    test_logic_zero();
    test_backpressure();
    test_tie_alternation();
    test_reset_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
